bit_flip_locate: RTL and testbench

//  Receive-side counterpart of the bit-flip injector: compares a reference word against a

---
 rtl/bit_flip_locate.sv | 143 ++++++++++++++
 tb/tb_bit_flip_locate.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_flip_locate.sv
// ---------------------------------------------------------------------------
// bit_flip_locate
//   Receive-side counterpart of the bit-flip injector. Compares a captured
//   reference word against a captured (possibly corrupted) word, one bit per
//   clock, and reports:
//   - the lowest flipped bit position;
//   - the number of flipped bits;
//   - a multi-flip flag.
//
//   Optional feature macro: BIT_FLIP_LOCATE_CORRECT_EN
//     When defined, out is the captured word with the located bit inverted
//     whenever exactly one bit was flipped. In every other case out is the
//     captured word unchanged.
//     When undefined, out is always the captured word and no correction
//     logic is built.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       level; sampled only in IDLE, high captures the operands
//   ref_word    expected (uncorrupted) word
//   in          received, possibly flipped, word
//   busy        high in SCAN and DONE
//   done        one-cycle pulse; results valid from this cycle on
//   found       at least one bit differs
//   index       lowest differing bit position (0 if !found)
//   flip_count  number of differing bits, 0..WIDTH
//   multi       flip_count > 1
//   out         captured word, optionally single-bit corrected
// ---------------------------------------------------------------------------
module bit_flip_locate #(
    parameter  int WIDTH = 32,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  ref_word,
    input  logic [WIDTH-1:0]  in,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [IDXW-1:0]   index,
    output logic [IDXW:0]     flip_count,
    output logic              multi,
    output logic [WIDTH-1:0]  out
);

    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             capture;
    logic             scan_last;
    logic [IDXW-1:0]  cnt;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] in_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        scan_last = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (cnt == LAST) begin
                    scan_last = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and serial scan datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q     <= '0;
            in_q       <= '0;
            cnt        <= '0;
            found      <= 1'b0;
            index      <= '0;
            flip_count <= '0;
            done       <= 1'b0;
        end else begin
            // done is set only on the final scan edge, so it drops
            // by itself on the DONE->IDLE edge.
            done <= scan_last;
            if (capture) begin
                diff_q     <= ref_word ^ in;
                in_q       <= in;
                cnt        <= '0;
                found      <= 1'b0;
                index      <= '0;
                flip_count <= '0;
            end else if (state == SCAN) begin
                if (diff_q[cnt]) begin
                    flip_count <= flip_count + (IDXW+1)'(1);
                    // Scan runs low to high, so the first hit is the lowest.
                    if (!found) begin
                        found <= 1'b1;
                        index <= cnt;
                    end
                end
                if (!scan_last) cnt <= cnt + IDXW'(1);
            end
        end
    end

    assign busy  = (state != IDLE);
    assign multi = (flip_count > (IDXW+1)'(1));

`ifdef BIT_FLIP_LOCATE_CORRECT_EN
    // Only a single flip is correctable. With more than one flip, the
    // located bit alone does not restore the word, so the captured
    // word is passed through unchanged.
    logic [WIDTH-1:0] fix_mask;
    assign fix_mask = (flip_count == (IDXW+1)'(1))
                      ? ({{(WIDTH-1){1'b0}}, 1'b1} << index) : '0;
    assign out = in_q ^ fix_mask;
`else
    assign out = in_q;
`endif

endmodule

// File: tb/tb_bit_flip_locate.sv
// ---------------------------------------------------------------------------
// tb_bit_flip_locate
//   Directed plus randomized self-checking bench for bit_flip_locate
//   (WIDTH=32). Expected results come from a word-level reference model:
//   - the popcount of ref^in gives the flip count;
//   - the lowest set bit of ref^in gives the index;
//   - the corrected output is the reference word when exactly one bit
//     flipped.
// ---------------------------------------------------------------------------
module tb_bit_flip_locate;

    localparam int W  = 32;
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  ref_word = '0;
    logic [W-1:0]  in = '0;
    logic          busy, done, found, multi;
    logic [IW-1:0] index;
    logic [IW:0]   flip_count;
    logic [W-1:0]  out;

    int n_cmp = 0;
    int n_bad = 0;

    bit_flip_locate #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ref_word(ref_word), .in(in),
        .busy(busy), .done(done), .found(found), .index(index),
        .flip_count(flip_count), .multi(multi), .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference model
    function automatic void model(input logic [W-1:0] r, input logic [W-1:0] i,
                                  output logic e_found, output int e_idx, output int e_cnt,
                                  output logic e_multi, output logic [W-1:0] e_out);
        logic [W-1:0] d, low;
        d       = r ^ i;
        low     = d & (~d + 1'b1);          // isolate lowest set bit
        e_cnt   = $countones(d);
        e_found = (d != 0);
        e_idx   = e_found ? $clog2(low) : 0;
        e_multi = (e_cnt > 1);
`ifdef BIT_FLIP_LOCATE_CORRECT_EN
        e_out   = (e_cnt == 1) ? r : i;
`else
        e_out   = i;
`endif
    endfunction

    task automatic check_results(input string tag, input logic [W-1:0] r, input logic [W-1:0] i);
        logic e_found, e_multi;
        int e_idx, e_cnt;
        logic [W-1:0] e_out;
        model(r, i, e_found, e_idx, e_cnt, e_multi, e_out);
        chk({tag, ".found"}, found, e_found);
        chk({tag, ".index"}, index, e_idx);
        chk({tag, ".count"}, flip_count, e_cnt);
        chk({tag, ".multi"}, multi, e_multi);
        chk({tag, ".out"},   out, e_out);
    endtask

    // Apply operands with a one-cycle start pulse; returns after the capture edge.
    task automatic start_scan(input logic [W-1:0] r, input logic [W-1:0] i);
        @(negedge clk);
        ref_word = r;
        in       = i;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        // Later operand changes must not disturb the running scan.
        ref_word = $urandom;
        in       = $urandom;
    endtask

    // Count clock edges from capture until done is seen (bounded).
    // repulse_at >= 0 raises start for one cycle at that scan cycle.
    task automatic wait_done(input int repulse_at, output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == repulse_at)     start = 1'b1;
            if (cyc == repulse_at + 1) start = 1'b0;
            if (done) break;
        end
    endtask

    task automatic full_scan(input string tag, input logic [W-1:0] r, input logic [W-1:0] i);
        int cyc;
        start_scan(r, i);
        wait_done(-1, cyc);
        chk({tag, ".latency"}, cyc, 32);
        chk({tag, ".busy_at_done"}, busy, 1'b1);
        check_results(tag, r, i);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, done, 1'b0);
        chk({tag, ".idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int cyc, ndone;
        logic [W-1:0] r, i, nr, ni;

        // Reset state
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.found", found, 0);
        chk("rst.index", index, 0);
        chk("rst.count", flip_count, 0);
        chk("rst.multi", multi, 0);
        chk("rst.out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. single flip at bit 16
        full_scan("t1", 32'h0, 32'h0001_0000);
        chk("t1.index_const", index, 16);

        // 2. no flips
        full_scan("t2", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk("t2.out_const", out, 32'hDEAD_BEEF);

        // 3. three flips, lowest at 0
        full_scan("t3", 32'h0, 32'h8000_0003);
        chk("t3.out_const", out, 32'h8000_0003);

        // 4. all bits flipped, start re-pulsed mid-scan
        start_scan(32'h0, 32'hFFFF_FFFF);
        wait_done(10, cyc);
        chk("t4.latency", cyc, 32);
        check_results("t4", 32'h0, 32'hFFFF_FFFF);
        chk("t4.count_const", flip_count, 32);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t4.no_second_done", ndone, 0);
        chk("t4.hold_count", flip_count, 32);

        // 5. reset mid-scan, then recover
        start_scan(32'h0, 32'hFFFF_FFFF);
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5.busy", busy, 0);
        chk("t5.done", done, 0);
        chk("t5.found", found, 0);
        chk("t5.index", index, 0);
        chk("t5.count", flip_count, 0);
        chk("t5.multi", multi, 0);
        chk("t5.out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        full_scan("t5b", 32'h0, 32'h0000_0080);
        chk("t5b.index_const", index, 7);

        // Randomized single-pulse scans across flip-density classes
        for (int k = 0; k < 12; k++) begin
            r = $urandom;
            case (k % 4)
                0: i = r ^ (32'h1 << $urandom_range(31));
                1: i = r ^ ($urandom & $urandom & $urandom);
                2: i = $urandom;
                default: i = (k == 3) ? r : ~r;
            endcase
            full_scan("rnd", r, i);
        end

        // 6. start held high: back-to-back scans every 34 cycles
        @(negedge clk);
        r = $urandom; i = r ^ 32'h0000_0400;
        ref_word = r; in = i; start = 1'b1;
        @(posedge clk);
        wait_done(-1, cyc);
        chk("t6.first_latency", cyc, 32);
        for (int k = 0; k < 4; k++) begin
            check_results("t6", r, i);
            nr = $urandom;
            ni = (k % 2 == 0) ? (nr ^ (32'h1 << $urandom_range(31))) : $urandom;
            ref_word = nr; in = ni;
            r = nr; i = ni;
            cyc = 0;
            while (cyc < 100) begin
                @(posedge clk);
                cyc++;
                #1;
                if (done) break;
            end
            chk("t6.period", cyc, 34);
        end
        start = 1'b0;
        check_results("t6", r, i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
